// File: rtl/ddrbus_sequencer_if.sv
// Controller/pad-facing signal bundle for ddrbus_sequencer.
// The slave modport is the sequencer; master is the controller and pad model.
interface ddrbus_sequencer_if #(
  parameter int LANES = 8,
  parameter int LENW  = 8
);
  logic                 i_cmd_stb;
  logic                 o_cmd_ready;
  logic                 i_cmd_rd;
  logic [LENW-1:0]      i_cmd_len;
  logic                 i_wr_valid;
  logic                 o_wr_ready;
  logic [4*LANES-1:0]   i_wr_data;
  logic                 o_rd_valid;
  logic [4*LANES-1:0]   o_rd_data;
  logic                 o_pad_we;
  logic [2*LANES-1:0]   o_pad_data;
  logic [2*LANES-1:0]   i_pad_data;
  logic                 o_busy;
  logic                 o_err;

  modport slave (
    input  i_cmd_stb, i_cmd_rd, i_cmd_len, i_wr_valid, i_wr_data, i_pad_data,
    output o_cmd_ready, o_wr_ready, o_rd_valid, o_rd_data, o_pad_we, o_pad_data,
           o_busy, o_err
  );

  modport master (
    output i_cmd_stb, i_cmd_rd, i_cmd_len, i_wr_valid, i_wr_data, i_pad_data,
    input  o_cmd_ready, o_wr_ready, o_rd_valid, o_rd_data, o_pad_we, o_pad_data,
           o_busy, o_err
  );
endinterface

// File: rtl/ddrbus_sequencer.sv
// DDR pad-bank sequencer: one word = two DDR beats on write, two beats = one word on read.
// Optional DDRBUS_ERRCOUNT_EN adds o_underruns, a saturating count of underrun pulses.
module ddrbus_sequencer #(
  parameter int LANES      = 8,
  parameter int LENW       = 8,
  parameter int RD_LATENCY = 3,
  parameter int TURNAROUND = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  ddrbus_sequencer_if.slave   bus
`ifdef DDRBUS_ERRCOUNT_EN
  ,
  output logic [15:0]         o_underruns
`endif
);

  localparam int HW   = 2 * LANES;
  localparam int WW   = 4 * LANES;
  localparam int LATW = $clog2(RD_LATENCY + 1) + 1;
  localparam int TW   = $clog2(TURNAROUND + 1) + 1;
  localparam logic [LATW-1:0] LAT_INIT  = LATW'(RD_LATENCY > 1 ? RD_LATENCY - 1 : 0);
  localparam logic [TW-1:0]   TURN_INIT = TW'(TURNAROUND > 0 ? TURNAROUND - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ_WAIT, S_READ, S_TURN
  } state_t;

  // Lane k carries half-word bit L+k in the first half-cycle and bit k in the second.
  function automatic logic [HW-1:0] to_pad(input logic [HW-1:0] h);
    logic [HW-1:0] p;
    p = '0;
    for (int k = 0; k < LANES; k++) begin
      p[2*k]   = h[LANES+k];
      p[2*k+1] = h[k];
    end
    return p;
  endfunction

  function automatic logic [HW-1:0] from_pad(input logic [HW-1:0] p);
    logic [HW-1:0] h;
    h = '0;
    for (int k = 0; k < LANES; k++) begin
      h[LANES+k] = p[2*k];
      h[k]       = p[2*k+1];
    end
    return h;
  endfunction

  state_t          state_q;
  logic [LENW-1:0] cnt_q;
  logic            phase_q;
  logic            beat_q;
  logic [LATW-1:0] lat_q;
  logic [TW-1:0]   turn_q;
  logic [HW-1:0]   hold_q;
  logic [HW-1:0]   rd_hold_q;
  logic [WW-1:0]   rd_data_q;
  logic            rd_valid_q;
  logic            pad_we_q;
  logic [HW-1:0]   pad_dat_q;
  logic            err_q;

  logic [HW-1:0]   wr_beat0_d;
  logic [HW-1:0]   wr_beat1_d;
  logic [HW-1:0]   rd_half_d;
  state_t          turn_state_d;

  assign wr_beat0_d   = to_pad(bus.i_wr_data[WW-1:HW]);
  assign wr_beat1_d   = to_pad(hold_q);
  assign rd_half_d    = from_pad(bus.i_pad_data);
  assign turn_state_d = (TURNAROUND == 0) ? S_IDLE : S_TURN;

  // phase_q=1 while the pad shows beat0; the next word is due on the beat1 cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      beat_q     <= 1'b0;
      lat_q      <= '0;
      turn_q     <= '0;
      hold_q     <= '0;
      rd_hold_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      pad_we_q   <= 1'b0;
      pad_dat_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          pad_we_q  <= 1'b0;
          pad_dat_q <= '0;
          if (bus.i_cmd_stb && (bus.i_cmd_len != '0)) begin
            cnt_q   <= bus.i_cmd_len;
            phase_q <= 1'b0;
            beat_q  <= 1'b0;
            lat_q   <= LAT_INIT;
            if (bus.i_cmd_rd) state_q <= (RD_LATENCY <= 1) ? S_READ : S_READ_WAIT;
            else              state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (phase_q) begin
            pad_dat_q <= wr_beat1_d;
            phase_q   <= 1'b0;
          end else if (cnt_q == '0) begin
            pad_we_q  <= 1'b0;
            pad_dat_q <= '0;
            turn_q    <= TURN_INIT;
            state_q   <= turn_state_d;
          end else if (bus.i_wr_valid) begin
            pad_dat_q <= wr_beat0_d;
            pad_we_q  <= 1'b1;
            hold_q    <= bus.i_wr_data[HW-1:0];
            cnt_q     <= cnt_q - LENW'(1);
            phase_q   <= 1'b1;
          end else begin
            err_q     <= 1'b1;
            pad_we_q  <= 1'b0;
            pad_dat_q <= '0;
            turn_q    <= TURN_INIT;
            state_q   <= turn_state_d;
          end
        end
        S_READ_WAIT: begin
          if (lat_q <= LATW'(1)) state_q <= S_READ;
          else                   lat_q   <= lat_q - LATW'(1);
        end
        S_READ: begin
          beat_q <= ~beat_q;
          if (!beat_q) begin
            rd_hold_q <= rd_half_d;
          end else begin
            rd_data_q  <= {rd_hold_q, rd_half_d};
            rd_valid_q <= 1'b1;
            cnt_q      <= cnt_q - LENW'(1);
            if (cnt_q == LENW'(1)) begin
              turn_q  <= TURN_INIT;
              state_q <= turn_state_d;
            end
          end
        end
        S_TURN: begin
          if (turn_q == '0) state_q <= S_IDLE;
          else              turn_q  <= turn_q - TW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_cmd_ready = (state_q == S_IDLE);
  assign bus.o_busy      = (state_q != S_IDLE);
  assign bus.o_wr_ready  = (state_q == S_WRITE) && !phase_q && (cnt_q != '0);
  assign bus.o_rd_valid  = rd_valid_q;
  assign bus.o_rd_data   = rd_data_q;
  assign bus.o_pad_we    = pad_we_q;
  assign bus.o_pad_data  = pad_dat_q;
  assign bus.o_err       = err_q;

`ifdef DDRBUS_ERRCOUNT_EN
  logic [15:0] underruns_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      underruns_q <= '0;
    end else if (err_q && (underruns_q != 16'hffff)) begin
      underruns_q <= underruns_q + 16'd1;
    end
  end

  assign o_underruns = underruns_q;
`endif

endmodule

// File: tb/tb_ddrbus_sequencer.sv
// Scoreboard bench for ddrbus_sequencer: pad beats and read words are queued when driven
// and checked by a negedge monitor; each scenario task also checks timing inline.
module tb_ddrbus_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [15:0] exp_beats[$];
  logic [31:0] exp_words[$];
  logic [15:0] rd_beats[$];
  int          exp_under;

  ddrbus_sequencer_if #(.LANES(8), .LENW(8)) bus ();

`ifdef DDRBUS_ERRCOUNT_EN
  logic [15:0] underruns;
  ddrbus_sequencer dut (.i_clk(clk), .i_reset(rst), .bus(bus), .o_underruns(underruns));
`else
  ddrbus_sequencer dut (.i_clk(clk), .i_reset(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Bench model of the lane mapping: even pad bits carry the upper byte.
  function automatic logic [15:0] beat_of(input logic [15:0] h);
    logic [15:0] p;
    for (int b = 0; b < 16; b++) p[b] = b[0] ? h[b >> 1] : h[8 + (b >> 1)];
    return p;
  endfunction

  function automatic logic [7:0] evens(input logic [15:0] p);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = p[2*k];
    return r;
  endfunction

  function automatic logic [7:0] odds(input logic [15:0] p);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = p[2*k+1];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_pad_we) begin
        total++;
        if (exp_beats.size() == 0) begin
          bad++;
          $display("FAIL pad_beat unexpected got=%h", bus.o_pad_data);
        end else begin
          logic [15:0] e;
          e = exp_beats.pop_front();
          if (bus.o_pad_data !== e) begin
            bad++;
            $display("FAIL pad_beat got=%h want=%h", bus.o_pad_data, e);
          end
        end
      end
      if (bus.o_rd_valid) begin
        total++;
        if (exp_words.size() == 0) begin
          bad++;
          $display("FAIL rd_word unexpected got=%h", bus.o_rd_data);
        end else begin
          logic [31:0] w;
          w = exp_words.pop_front();
          if (bus.o_rd_data !== w) begin
            bad++;
            $display("FAIL rd_word got=%h want=%h", bus.o_rd_data, w);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.o_cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (bus.o_cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL wait_ready timeout got=%b want=1", bus.o_cmd_ready);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({bus.o_pad_we, bus.o_wr_ready, bus.o_rd_valid, bus.o_err, bus.o_busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {bus.o_pad_we, bus.o_wr_ready, bus.o_rd_valid, bus.o_err, bus.o_busy});
    end
    total++;
    if (bus.o_pad_data !== 16'h0 || bus.o_rd_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got pad=%h rd=%h want=0", bus.o_pad_data, bus.o_rd_data);
    end
`ifdef DDRBUS_ERRCOUNT_EN
    total++;
    if (underruns !== 16'h0) begin
      bad++;
      $display("FAIL reset_underruns got=%h want=0", underruns);
    end
`endif
    rst = 1'b0;
    tick();
    total++;
    if (bus.o_cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_cmd_ready got=%b want=1", bus.o_cmd_ready);
    end
  endtask

  task automatic test_write_single();
    wait_ready();
    bus.i_cmd_stb = 1'b1; bus.i_cmd_rd = 1'b0; bus.i_cmd_len = 8'd1;
    bus.i_wr_valid = 1'b1; bus.i_wr_data = 32'h12345678;
    exp_beats.push_back(beat_of(16'h1234));
    exp_beats.push_back(beat_of(16'h5678));
    tick();
    bus.i_cmd_stb = 1'b0;
    total++;
    if (bus.o_wr_ready !== 1'b1 || bus.o_busy !== 1'b1) begin
      bad++;
      $display("FAIL single_ready got rdy=%b busy=%b want=1,1", bus.o_wr_ready, bus.o_busy);
    end
    tick();
    bus.i_wr_valid = 1'b0;
    total++;
    if (bus.o_pad_we !== 1'b1 || evens(bus.o_pad_data) !== 8'h12 || odds(bus.o_pad_data) !== 8'h34) begin
      bad++;
      $display("FAIL single_beat0 got we=%b pad=%h want we=1 even=12 odd=34", bus.o_pad_we, bus.o_pad_data);
    end
    tick();
    total++;
    if (bus.o_pad_we !== 1'b1 || evens(bus.o_pad_data) !== 8'h56 || odds(bus.o_pad_data) !== 8'h78) begin
      bad++;
      $display("FAIL single_beat1 got we=%b pad=%h want we=1 even=56 odd=78", bus.o_pad_we, bus.o_pad_data);
    end
    for (int t = 0; t < 2; t++) begin
      tick();
      total++;
      if (bus.o_pad_we !== 1'b0 || bus.o_cmd_ready !== 1'b0) begin
        bad++;
        $display("FAIL single_turn%0d got we=%b rdy=%b want=0,0", t, bus.o_pad_we, bus.o_cmd_ready);
      end
    end
    tick();
    total++;
    if (bus.o_cmd_ready !== 1'b1 || bus.o_busy !== 1'b0 || exp_beats.size() != 0) begin
      bad++;
      $display("FAIL single_done got rdy=%b busy=%b left=%0d want 1,0,0",
               bus.o_cmd_ready, bus.o_busy, exp_beats.size());
    end
  endtask

  task automatic test_write_burst();
    logic [31:0] w[4];
    int idx, wecnt, rises;
    logic prev, acc;
    wait_ready();
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      exp_beats.push_back(beat_of(w[i][31:16]));
      exp_beats.push_back(beat_of(w[i][15:0]));
    end
    idx = 0; wecnt = 0; rises = 0; prev = 1'b0;
    bus.i_cmd_stb = 1'b1; bus.i_cmd_rd = 1'b0; bus.i_cmd_len = 8'd4;
    bus.i_wr_valid = 1'b1; bus.i_wr_data = w[0];
    for (int cyc = 0; cyc < 30; cyc++) begin
      acc = bus.i_wr_valid && bus.o_wr_ready;
      if (bus.o_pad_we) wecnt++;
      if (bus.o_pad_we && !prev) rises++;
      prev = bus.o_pad_we;
      tick();
      // A stray read command mid-burst must be ignored.
      bus.i_cmd_stb = (cyc == 2);
      bus.i_cmd_rd = 1'b1; bus.i_cmd_len = 8'd5;
      if (acc) begin
        idx++;
        if (idx < 4) bus.i_wr_data = w[idx];
        else bus.i_wr_valid = 1'b0;
      end
    end
    bus.i_cmd_rd = 1'b0;
    total++;
    if (wecnt !== 8 || rises !== 1 || idx !== 4) begin
      bad++;
      $display("FAIL burst_gapless got we_cycles=%0d rises=%0d words=%0d want 8,1,4", wecnt, rises, idx);
    end
    total++;
    if (exp_beats.size() != 0 || bus.o_busy !== 1'b0) begin
      bad++;
      $display("FAIL burst_done got left=%0d busy=%b want 0,0", exp_beats.size(), bus.o_busy);
    end
  endtask

  task automatic test_underrun();
    for (int sc = 0; sc < 2; sc++) begin
      int errcnt;
      logic we_at_err, prev_at_err, prev;
      logic [31:0] w0;
      wait_ready();
      w0 = $urandom;
      errcnt = 0; we_at_err = 1'bx; prev_at_err = 1'bx; prev = 1'b0;
      if (sc == 0) begin
        exp_beats.push_back(beat_of(w0[31:16]));
        exp_beats.push_back(beat_of(w0[15:0]));
      end
      bus.i_cmd_stb = 1'b1; bus.i_cmd_rd = 1'b0; bus.i_cmd_len = (sc == 0) ? 8'd3 : 8'd2;
      bus.i_wr_valid = (sc == 0); bus.i_wr_data = w0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        if (bus.o_err) begin
          errcnt++;
          we_at_err = bus.o_pad_we;
          prev_at_err = prev;
        end
        prev = bus.o_pad_we;
        if (bus.i_wr_valid && bus.o_wr_ready) begin
          tick();
          bus.i_wr_valid = 1'b0;
        end else begin
          tick();
        end
        bus.i_cmd_stb = 1'b0;
      end
      exp_under++;
      total++;
      if (errcnt !== 1) begin
        bad++;
        $display("FAIL underrun%0d_pulses got=%0d want=1", sc, errcnt);
      end
      total++;
      if (we_at_err !== 1'b0 || prev_at_err !== (sc == 0)) begin
        bad++;
        $display("FAIL underrun%0d_we got err_we=%b prev_we=%b want 0,%0d", sc, we_at_err, prev_at_err, sc == 0);
      end
      total++;
      if (bus.o_cmd_ready !== 1'b1 || exp_beats.size() != 0) begin
        bad++;
        $display("FAIL underrun%0d_idle got rdy=%b left=%0d want 1,0", sc, bus.o_cmd_ready, exp_beats.size());
      end
    end
`ifdef DDRBUS_ERRCOUNT_EN
    total++;
    if (underruns !== 16'(exp_under)) begin
      bad++;
      $display("FAIL underrun_count got=%0d want=%0d", underruns, exp_under);
    end
`endif
  endtask

  task automatic run_read(input int len, input logic [31:0] last_word);
    int pulses, wecnt;
    wait_ready();
    pulses = 0; wecnt = 0;
    bus.i_cmd_stb = 1'b1; bus.i_cmd_rd = 1'b1; bus.i_cmd_len = 8'(len);
    for (int cyc = 0; cyc < 3 + 2*len + 6; cyc++) begin
      bus.i_pad_data = (cyc >= 3 && cyc < 3 + 2*len) ? rd_beats[cyc-3] : 16'hDEAD;
      if (bus.o_rd_valid) pulses++;
      if (bus.o_pad_we) wecnt++;
      tick();
      bus.i_cmd_stb = 1'b0;
    end
    bus.i_cmd_rd = 1'b0;
    total++;
    if (pulses !== len || wecnt !== 0) begin
      bad++;
      $display("FAIL read%0d_pulses got pulses=%0d we_cycles=%0d want %0d,0", len, pulses, wecnt, len);
    end
    total++;
    if (bus.o_rd_data !== last_word || exp_words.size() != 0 || bus.o_cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL read%0d_hold got data=%h left=%0d rdy=%b want %h,0,1",
               len, bus.o_rd_data, exp_words.size(), bus.o_cmd_ready, last_word);
    end
  endtask

  task automatic test_read();
    logic [31:0] w;
    // 0xAAAA: even bits 0x00 -> upper byte, odd bits 0xFF -> lower byte.
    rd_beats = '{16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0};
    exp_words.push_back(32'h00FFFF00);
    exp_words.push_back(32'h3333CCCC);
    run_read(2, 32'h3333CCCC);
    rd_beats.delete();
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      rd_beats.push_back(beat_of(w[31:16]));
      rd_beats.push_back(beat_of(w[15:0]));
      exp_words.push_back(w);
    end
    run_read(3, w);
  endtask

  task automatic test_len0();
    wait_ready();
    bus.i_cmd_stb = 1'b1; bus.i_cmd_rd = 1'b0; bus.i_cmd_len = 8'd0; bus.i_wr_valid = 1'b1;
    tick();
    bus.i_cmd_stb = 1'b0; bus.i_wr_valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
      total++;
      if (bus.o_busy !== 1'b0 || bus.o_pad_we !== 1'b0 || bus.o_cmd_ready !== 1'b1) begin
        bad++;
        $display("FAIL len0_c%0d got busy=%b we=%b rdy=%b want 0,0,1", t, bus.o_busy, bus.o_pad_we, bus.o_cmd_ready);
      end
      tick();
    end
  endtask

  task automatic test_reset_midburst();
    logic [31:0] w0;
    wait_ready();
    w0 = $urandom;
    exp_beats.push_back(beat_of(w0[31:16]));
    bus.i_cmd_stb = 1'b1; bus.i_cmd_rd = 1'b0; bus.i_cmd_len = 8'd2;
    bus.i_wr_valid = 1'b1; bus.i_wr_data = w0;
    tick();
    bus.i_cmd_stb = 1'b0;
    tick();
    tick();
    total++;
    if (bus.o_pad_we !== 1'b1 || bus.o_pad_data !== beat_of(w0[15:0])) begin
      bad++;
      $display("FAIL midrst_beat1 got we=%b pad=%h want 1,%h", bus.o_pad_we, bus.o_pad_data, beat_of(w0[15:0]));
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.o_pad_we !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_wr_ready !== 1'b0 || bus.o_pad_data !== 16'h0) begin
      bad++;
      $display("FAIL midrst_abort got we=%b busy=%b rdy=%b pad=%h want 0,0,0,0",
               bus.o_pad_we, bus.o_busy, bus.o_wr_ready, bus.o_pad_data);
    end
    tick();
    rst = 1'b0;
    bus.i_wr_valid = 1'b0;
    exp_under = 0;
    tick();
    total++;
    if (bus.o_cmd_ready !== 1'b1 || bus.o_rd_valid !== 1'b0 || exp_beats.size() != 0) begin
      bad++;
      $display("FAIL midrst_idle got rdy=%b rdv=%b left=%0d want 1,0,0", bus.o_cmd_ready, bus.o_rd_valid, exp_beats.size());
    end
`ifdef DDRBUS_ERRCOUNT_EN
    total++;
    if (underruns !== 16'(exp_under)) begin
      bad++;
      $display("FAIL midrst_underruns got=%0d want=%0d", underruns, exp_under);
    end
`endif
  endtask

  initial begin
    total = 0; bad = 0; exp_under = 0;
    rst = 1'b1;
    bus.i_cmd_stb = 1'b0; bus.i_cmd_rd = 1'b0; bus.i_cmd_len = '0;
    bus.i_wr_valid = 1'b0; bus.i_wr_data = '0; bus.i_pad_data = '0;
    tick();
    tick();
    test_reset();
    test_write_single();
    test_write_burst();
    test_underrun();
    test_read();
    test_len0();
    test_reset_midburst();
    test_write_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
